serial_add_arb: RTL and testbench
=================================

# serial_add_arb

Two-requester arbiter and bit-serial sequencer for a single shared 1-bit full-adder cell. It accepts WIDTH-bit add requests from two clients, grants one at a time, and streams the operands LSB-first through the one full-adder cell, keeping the carry in a flip-flop. It returns a WIDTH-bit sum, carry-out and requester ID through a valid/ready result port. It sits between the two operand producers and the downstream consumer, trading latency for area (one adder cell regardless of WIDTH).

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..32
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  synchronous, active-low reset (sampled on rising clk edge)
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 accepted this cycle when valid&ready
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  as requester 0, for requester 1
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result when res_valid&res_ready
- res_sum  out  WIDTH  a+b+cin modulo 2^WIDTH
- res_cout  out  1  carry out of bit WIDTH-1
- res_id  out  1  requester that issued the result (0/1)

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: the grant is computed combinationally from the valids. reqN_ready = (state==IDLE) & grant==N & rst_n. The ready outputs never depend on res_ready.
- On an accept edge:
  - latch the granted a, b and cin into shift regs A, B and carry flop C
  - bit counter ← 0, res_id ← grant
  - → RUN
- RUN, each edge:
  - cell inputs A[0], B[0], C
  - sum bit shifted into S at MSB, S shifts right
  - A and B shift right, C ← cell carry, counter+1
  - after the WIDTH-th RUN edge: res_cout ← cell carry, → DONE
- DONE:
  - res_valid=1; res_sum=S, res_cout and res_id held stable
  - on res_valid&res_ready → IDLE
  - no new accept in the same cycle (readys are 0 outside IDLE)
- Exactly one full-adder cell is instantiated. No other adder is inferred.
- A requester dropping valid before acceptance is legal and is not an error. A requester holding valid while the block is busy simply waits.
- Reset mid-RUN or mid-DONE: the operation is aborted and no result is emitted. A, B, C, S, counter, res_* and the arbitration state all clear.

## Timing
- Reset values: res_valid=0, res_sum=0, res_cout=0, res_id=0, req0_ready=0, req1_ready=0 (while rst_n=0); state=IDLE, C=0.
- Latency: the accept edge is E0. res_valid rises after edge E_WIDTH and is first visible in the cycle following that edge (8 edges for WIDTH=8).
- Minimum issue interval: WIDTH+2 cycles, made of accept, WIDTH RUN edges, and the DONE handshake edge; the block then re-enters IDLE.
- Back-pressure: res_ready low holds DONE indefinitely with all outputs stable.
- WIDTH=1: exactly one RUN edge.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - a last_grant flop is updated on every accept; reset value 1, so requester 0 wins the first tie
  - when both valids are high in IDLE, grant = ~last_grant
  - a single valid is always granted
- ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins ties, and no last_grant flop exists.

## Test plan
- WIDTH=8, req0 a=0x5A b=0x3C cin=0 → res_sum=0x96, res_cout=0, res_id=0; res_valid visible after 8 edges past accept.
- req1 a=0xFF b=0x01 cin=0 → res_sum=0x00, res_cout=1, res_id=1. Then a=0xFF b=0xFF cin=1 → res_sum=0xFF, res_cout=1.
- Both valids held high for 3 operations, res_ready=1: macro undefined → res_id sequence 0,0,0; macro defined → 0,1,0. In both cases the losing ready stays 0.
- In DONE, res_ready=0 for 5 cycles → res_valid, res_sum and res_id are unchanged, both readys stay 0, and the pending req1 is not accepted until the cycle after the handshake.
- req0 a=0xFF b=0x01 is accepted, then rst_n=0 for 1 cycle after the 3rd RUN edge → res_valid never asserts and the state is IDLE. Next, a=0x01 b=0x01 cin=0 → res_sum=0x02, res_cout=0, confirming the carry flop was cleared.
- WIDTH=1 build: a=1 b=1 cin=1 → res_sum=1, res_cout=1, res_valid one edge after accept.

Source files
------------

// File: rtl/serial_add_arb.sv
// serial_add_arb: two-requester arbiter feeding one shared bit-serial full-adder cell.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module serial_add_arb #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             res_id
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic             c_q, c_d, cout_q, cout_d, id_q, id_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             grant, accept, fa_sum, fa_carry;
   logic [WIDTH:0]   s_shift;

   // The one shared full-adder cell.
   assign fa_sum   = a_q[0] ^ b_q[0] ^ c_q;
   assign fa_carry = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

   // New sum bit enters at the MSB while S shifts right.
   assign s_shift = {fa_sum, s_q};

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant_q;

   always_comb begin
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else begin
         grant = req1_valid & ~req0_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else if (accept) begin
         last_grant_q <= grant;
      end
   end
`else
   assign grant = req1_valid & ~req0_valid;
`endif

   assign req0_ready = (state_q == StIdle) & ~grant & rst_n;
   assign req1_ready = (state_q == StIdle) & grant & rst_n;
   assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      cout_d  = cout_q;
      id_d    = id_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               a_d     = grant ? req1_a : req0_a;
               b_d     = grant ? req1_b : req0_b;
               c_d     = grant ? req1_cin : req0_cin;
               cnt_d   = '0;
               id_d    = grant;
               state_d = StRun;
            end
         end
         StRun: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = fa_carry;
            s_d   = s_shift[WIDTH:1];
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               cout_d  = fa_carry;
               state_d = StDone;
            end
         end
         StDone: begin
            if (res_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         s_q     <= '0;
         cnt_q   <= '0;
         cout_q  <= 1'b0;
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         cout_q  <= cout_d;
         id_q    <= id_d;
      end
   end

   assign res_valid = (state_q == StDone);
   assign res_sum   = s_q;
   assign res_cout  = cout_q;
   assign res_id    = id_q;

endmodule

// File: tb/tb_serial_add_arb.sv
// Self-checking bench for serial_add_arb: directed table, hand sequences, random ops vs model.
module tb_serial_add_arb;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b, res_sum;
   logic         res_valid, res_ready, res_cout, res_id;

   logic         w1_req0_valid, w1_req0_ready, w1_req0_cin, w1_req1_valid, w1_req1_ready;
   logic         w1_req1_cin, w1_res_valid, w1_res_ready, w1_res_cout, w1_res_id;
   logic [0:0]   w1_req0_a, w1_req0_b, w1_req1_a, w1_req1_b, w1_res_sum;

   int   checks = 0;
   int   errors = 0;
   logic last_g;

   typedef struct {
      logic         v0;
      logic [W-1:0] a0;
      logic [W-1:0] b0;
      logic         c0;
      logic         v1;
      logic [W-1:0] a1;
      logic [W-1:0] b1;
      logic         c1;
      logic         k0;
      logic         k1;
      int           bp;
      logic [W-1:0] es;
      logic         ec;
      logic         eid;
   } vec_t;

   always #5 clk = ~clk;

   serial_add_arb #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_cin   (req0_cin),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_cin   (req1_cin),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sum    (res_sum),
      .res_cout   (res_cout),
      .res_id     (res_id)
   );

   serial_add_arb #(.WIDTH(1)) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (w1_req0_valid),
      .req0_ready (w1_req0_ready),
      .req0_a     (w1_req0_a),
      .req0_b     (w1_req0_b),
      .req0_cin   (w1_req0_cin),
      .req1_valid (w1_req1_valid),
      .req1_ready (w1_req1_ready),
      .req1_a     (w1_req1_a),
      .req1_b     (w1_req1_b),
      .req1_cin   (w1_req1_cin),
      .res_valid  (w1_res_valid),
      .res_ready  (w1_res_ready),
      .res_sum    (w1_res_sum),
      .res_cout   (w1_res_cout),
      .res_id     (w1_res_id)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Lowest index wins unless round-robin alternates on a tie.
   function automatic logic model_grant(input logic v0, input logic v1);
`ifdef ARB_ROUND_ROBIN_EN
      if (v0 && v1) return ~last_g;
`endif
      return v0 ? 1'b0 : v1;
   endfunction

   function automatic vec_t mk(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic c0, input logic v1, input logic [W-1:0] a1,
                               input logic [W-1:0] b1, input logic c1, input logic k0,
                               input logic k1, input int bp, input logic [W-1:0] es,
                               input logic ec, input logic eid);
      vec_t v;
      v.v0 = v0; v.a0 = a0; v.b0 = b0; v.c0 = c0;
      v.v1 = v1; v.a1 = a1; v.b1 = b1; v.c1 = c1;
      v.k0 = k0; v.k1 = k1; v.bp = bp;
      v.es = es; v.ec = ec; v.eid = eid;
      return v;
   endfunction

   task automatic run_op(input vec_t v, input string name);
      logic g;
      int   n;
      req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_cin = v.c0;
      req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_cin = v.c1;
      res_ready  = 1'b1;
      g = model_grant(v.v0, v.v1);
      #1;
      check({name, " idle rdy0"}, 32'(req0_ready), 32'(!g));
      check({name, " idle rdy1"}, 32'(req1_ready), 32'(g));
      step();
      last_g = g;
      req0_valid = v.v0 & v.k0;
      req1_valid = v.k1;
      n = 0;
      while (!res_valid && n < int'(W) + 4) begin
         step();
         n++;
      end
      check({name, " latency"}, 32'(n), 32'(W));
      check({name, " sum"}, 32'(res_sum), 32'(v.es));
      check({name, " cout"}, 32'(res_cout), 32'(v.ec));
      check({name, " id"}, 32'(res_id), 32'(v.eid));
      check({name, " done rdy"}, 32'({req0_ready, req1_ready}), 32'(0));
      res_ready = 1'b0;
      for (int i = 0; i < v.bp; i++) begin
         step();
         check({name, " bp valid"}, 32'(res_valid), 32'(1));
         check({name, " bp sum"}, 32'(res_sum), 32'(v.es));
         check({name, " bp cout/id"}, 32'({res_cout, res_id}), 32'({v.ec, v.eid}));
         check({name, " bp rdy"}, 32'({req0_ready, req1_ready}), 32'(0));
      end
      res_ready = 1'b1;
      step();
      check({name, " post handshake valid"}, 32'(res_valid), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout: got stuck expected finish");
      $fatal(1);
   end

   initial begin
      vec_t         tbl[8];
      vec_t         rv;
      logic [W:0]   tot;
      logic [2:0]   tie_id;

`ifdef ARB_ROUND_ROBIN_EN
      tie_id = 3'b010;
`else
      tie_id = 3'b000;
`endif
      tbl[0] = mk(1, 8'h10, 8'h01, 0, 1, 8'h20, 8'h02, 0, 1, 1, 0,
                  tie_id[2] ? 8'h22 : 8'h11, 0, tie_id[2]);
      tbl[1] = mk(1, 8'h10, 8'h01, 0, 1, 8'h20, 8'h02, 0, 1, 1, 0,
                  tie_id[1] ? 8'h22 : 8'h11, 0, tie_id[1]);
      tbl[2] = mk(1, 8'h10, 8'h01, 0, 1, 8'h20, 8'h02, 0, 1, 1, 0,
                  tie_id[0] ? 8'h22 : 8'h11, 0, tie_id[0]);
      tbl[3] = mk(1, 8'h5A, 8'h3C, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h96, 0, 0);
      tbl[4] = mk(0, 8'h00, 8'h00, 0, 1, 8'hFF, 8'h01, 0, 0, 0, 0, 8'h00, 1, 1);
      tbl[5] = mk(0, 8'h00, 8'h00, 0, 1, 8'hFF, 8'hFF, 1, 0, 0, 0, 8'hFF, 1, 1);
      // req1 shows up while req0's result is back-pressured; must wait for IDLE.
      tbl[6] = mk(1, 8'h33, 8'h44, 1, 0, 8'h00, 8'h00, 0, 0, 1, 5, 8'h78, 0, 0);
      tbl[7] = mk(0, 8'h00, 8'h00, 0, 1, 8'h80, 8'h80, 0, 0, 0, 0, 8'h00, 1, 1);

      rst_n = 1'b0;
      req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
      req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
      res_ready = 1'b1;
      w1_req0_valid = 1'b0; w1_req0_a = '0; w1_req0_b = '0; w1_req0_cin = 1'b0;
      w1_req1_valid = 1'b0; w1_req1_a = '0; w1_req1_b = '0; w1_req1_cin = 1'b0;
      w1_res_ready = 1'b1;
      step();
      step();
      check("reset rdy", 32'({req0_ready, req1_ready}), 32'(0));
      check("reset valid", 32'(res_valid), 32'(0));
      check("reset sum", 32'(res_sum), 32'(0));
      check("reset cout/id", 32'({res_cout, res_id}), 32'(0));
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;
      last_g = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i], $sformatf("vec%0d", i));
      end

      // Abort mid-RUN: reset after the 3rd RUN edge must drop the operation.
      req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h01; req0_cin = 1'b0;
      step();
      req0_valid = 1'b0;
      step(); step(); step();
      rst_n = 1'b0;
      #1;
      check("abort rdy in reset", 32'({req0_ready, req1_ready}), 32'(0));
      step();
      rst_n = 1'b1;
      last_g = 1'b1;
      check("abort sum", 32'(res_sum), 32'(0));
      check("abort cout/id", 32'({res_cout, res_id}), 32'(0));
      for (int i = 0; i < int'(W) + 2; i++) begin
         check("abort no valid", 32'(res_valid), 32'(0));
         step();
      end
      check("abort idle rdy0", 32'(req0_ready), 32'(1));
      run_op(mk(1, 8'h01, 8'h01, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h02, 0, 0), "after abort");

      for (int i = 0; i < 24; i++) begin
         rv.v0 = 1'($urandom_range(0, 1));
         rv.v1 = rv.v0 ? 1'($urandom_range(0, 1)) : 1'b1;
         rv.a0 = W'($urandom); rv.b0 = W'($urandom); rv.c0 = 1'($urandom_range(0, 1));
         rv.a1 = W'($urandom); rv.b1 = W'($urandom); rv.c1 = 1'($urandom_range(0, 1));
         rv.k0 = 1'($urandom_range(0, 1));
         rv.k1 = 1'($urandom_range(0, 1));
         rv.bp = int'($urandom_range(0, 2));
         rv.eid = model_grant(rv.v0, rv.v1);
         tot = rv.eid ? ({1'b0, rv.a1} + {1'b0, rv.b1} + (W + 1)'(rv.c1))
                      : ({1'b0, rv.a0} + {1'b0, rv.b0} + (W + 1)'(rv.c0));
         rv.es = tot[W-1:0];
         rv.ec = tot[W];
         run_op(rv, $sformatf("rand%0d", i));
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // WIDTH=1 instance: single RUN edge.
      w1_req0_valid = 1'b1; w1_req0_a = 1'b1; w1_req0_b = 1'b1; w1_req0_cin = 1'b1;
      #1;
      check("w1 rdy0", 32'(w1_req0_ready), 32'(1));
      step();
      w1_req0_valid = 1'b0;
      check("w1 valid at accept", 32'(w1_res_valid), 32'(0));
      step();
      check("w1 valid", 32'(w1_res_valid), 32'(1));
      check("w1 sum/cout", 32'({w1_res_cout, w1_res_sum}), 32'(3));
      check("w1 id", 32'(w1_res_id), 32'(0));
      step();
      check("w1 post handshake", 32'(w1_res_valid), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
